// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back register file: 32 GPRs plus HI/LO, bypassed reads, write counter
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous reset, active-low
//   we/waddr/wdata    GPR write from write-back
//   whilo/hi_i/lo_i   HI/LO pair write from write-back
//   re1/raddr1/rdata1 read port 1 (combinational, bypassed)
//   re2/raddr2/rdata2 read port 2 (combinational, bypassed)
//   hi_o/lo_o         current HI/LO (combinational, bypassed)
//   wr_count          wrapping count of committed write events

module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       wr_count
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [31:0]       r_wr_count;

    // Writes to register 0 are discarded and do not count as events.
    logic        w_gpr_wr;
    logic [31:0] w_cnt_inc;

    assign w_gpr_wr  = we && (waddr != '0);
    assign w_cnt_inc = {31'd0, w_gpr_wr} + {31'd0, whilo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_gpr_wr) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (whilo) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else begin
            r_wr_count <= r_wr_count + w_cnt_inc;
        end
    end

    assign wr_count = r_wr_count;

    // Read port 1: the in-flight write wins over storage so decode sees it
    // in the same cycle it is committed.
    always_comb begin
        rdata1 = '0;
        if (!rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (whilo) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end else begin
            hi_o = r_hi;
            lo_o = r_lo;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .whilo    (whilo),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .wr_count (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        m_cnt = 32'd0;
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
        if (rst !== 1'b1 || !re || ra == 5'd0) return 32'd0;
        if (we && waddr == ra) return wdata;
        return m_regs[ra];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst !== 1'b1) return 32'd0;
        return whilo ? hi_i : m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst !== 1'b1) return 32'd0;
        return whilo ? lo_i : m_lo;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, "_rdata1"}, rdata1, exp_read(re1, raddr1));
        check({tag, "_rdata2"}, rdata2, exp_read(re2, raddr2));
        check({tag, "_hi_o"}, hi_o, exp_hi());
        check({tag, "_lo_o"}, lo_o, exp_lo());
    endtask

    // One rising edge; the model commits what was presented at that edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst === 1'b1) begin
            if (we && waddr != 5'd0) begin
                m_regs[waddr] = wdata;
                m_cnt = m_cnt + 32'd1;
            end
            if (whilo) begin
                m_hi  = hi_i;
                m_lo  = lo_i;
                m_cnt = m_cnt + 32'd1;
            end
        end
        #1;
        check({tag, "_wr_count"}, wr_count, m_cnt);
    endtask

    initial begin
        we = 0; waddr = 0; wdata = 0; whilo = 0; hi_i = 0; lo_i = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held with a write presented: nothing may leak through.
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF; re1 = 1; raddr1 = 5;
        #1;
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        step("rst_edge1");
        step("rst_edge2");
        rst = 1'b1;
        we  = 0;
        step("rst_release");
        #1;
        check("rst_reg5", rdata1, 32'd0);

        // Write then read from storage.
        we = 1; waddr = 3; wdata = 32'h1234_5678; re1 = 0;
        step("wr3");
        we = 0; re1 = 1; raddr1 = 3;
        #1;
        check("rd3_rdata1", rdata1, 32'h1234_5678);
        check("rd3_wr_count", wr_count, 32'd1);

        // Same-cycle bypass on both ports.
        we = 1; waddr = 7; wdata = 32'hA5A5_A5A5; re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 7;
        #1;
        check("byp_rdata1", rdata1, 32'hA5A5_A5A5);
        check("byp_rdata2", rdata2, 32'hA5A5_A5A5);
        step("byp");

        // Register 0 stays zero and the write is not counted.
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; raddr1 = 0;
        #1;
        check("r0_same", rdata1, 32'd0);
        step("r0");
        check("r0_count", wr_count, 32'd2);
        we = 0;
        #1;
        check("r0_next", rdata1, 32'd0);

        // HI/LO with a simultaneous GPR write: two events on one edge.
        whilo = 1; hi_i = 32'h0000_0001; lo_i = 32'h8000_0000;
        we = 1; waddr = 9; wdata = 32'h0BAD_F00D;
        #1;
        check("hilo_byp_hi", hi_o, 32'h0000_0001);
        check("hilo_byp_lo", lo_o, 32'h8000_0000);
        step("hilo");
        check("hilo_count", wr_count, 32'd4);
        whilo = 0; we = 0; hi_i = $urandom; lo_i = $urandom;
        #1;
        check("hilo_hold_hi", hi_o, 32'h0000_0001);
        check("hilo_hold_lo", lo_o, 32'h8000_0000);

        // Disabled read, then an asynchronous reset pulse between edges.
        re1 = 0; raddr1 = 3; re2 = 1; raddr2 = 3;
        #1;
        check("dis_rdata1", rdata1, 32'd0);
        check("en_rdata2", rdata2, 32'h1234_5678);
        rst = 1'b0;
        #1;
        check("arst_rdata2", rdata2, 32'd0);
        check("arst_hi", hi_o, 32'd0);
        check("arst_count", wr_count, 32'd0);
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_reg3", rdata2, 32'd0);
        check("arst_hi_after", hi_o, 32'd0);
        check("arst_lo_after", lo_o, 32'd0);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            we     = ($urandom_range(0, 3) != 0);
            waddr  = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
            wdata  = $urandom;
            whilo  = ($urandom_range(0, 2) == 0);
            hi_i   = $urandom;
            lo_i   = $urandom;
            re1    = ($urandom_range(0, 5) != 0);
            re2    = ($urandom_range(0, 5) != 0);
            raddr1 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 5));
            #1;
            check_comb("rnd");
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                #1;
                check_comb("rnd_arst");
                check("rnd_arst_count", wr_count, 32'd0);
                model_reset();
                rst = 1'b1;
                #1;
                check_comb("rnd_arst_rel");
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural state sink for the write-back stage: 32-entry general register file plus HI/LO pair.
- Consumes the write-back bundle (wd/wdata/wreg, hi/lo/whilo) registered by the MEM/WB pipeline register.
- Serves two decode-stage read ports and one HI/LO read port, with same-cycle write-to-read bypass.
- Keeps a wrapping count of committed architectural writes for debug/trace.

Parameters:
DATA_W, 32, register and HI/LO data width (matches RegBus)
ADDR_W, 5, register address width (matches RegAddrBus)
NUM_REGS, 32, number of GPRs; must equal 2**ADDR_W

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset asserted)
we  input  1  GPR write enable from WB (wb_wreg)
waddr  input  ADDR_W  GPR write address (wb_wd)
wdata  input  DATA_W  GPR write data (wb_wdata)
whilo  input  1  HI/LO write enable from WB (wb_whilo)
hi_i  input  DATA_W  HI write data (wb_hi)
lo_i  input  DATA_W  LO write data (wb_lo)
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data, combinational
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data, combinational
hi_o  output  DATA_W  current HI, combinational with bypass
lo_o  output  DATA_W  current LO, combinational with bypass
wr_count  output  32  number of committed GPR and HI/LO write events, registered

Behaviour:
- Reset (rst==0, asynchronous):
  - All GPRs, HI, LO and wr_count are cleared to 0.
  - rdata1, rdata2, hi_o and lo_o are forced to 0 while rst==0, regardless of the other inputs.
- GPR write:
  - At posedge clk, when we==1 and waddr!=0: reg[waddr] <= wdata.
  - waddr==0 is a silent discard; reg[0] is always 0.
- HI/LO write:
  - At posedge clk, when whilo==1: HI <= hi_i and LO <= lo_i.
  - Both are always written together.
- Read ports (each port independent, priority in this order):
  1. reset asserted -> 0
  2. reN==0 -> 0
  3. raddrN==0 -> 0
  4. we==1 and waddr==raddrN -> wdata (bypass)
  5. otherwise -> reg[raddrN]
- Bypass latency:
  - Data written in cycle N is visible on a read port in cycle N through the bypass path.
  - From cycle N+1 onward it is visible from storage.
  - There are no bubbles and no stalls; the block never back-pressures.
- HI/LO read:
  - hi_o = whilo ? hi_i : HI.
  - lo_o = whilo ? lo_i : LO.
- wr_count:
  - At posedge clk, wr_count increments by 1 if exactly one of (we && waddr!=0) or whilo is true.
  - It increments by 2 if both are true.
  - It wraps modulo 2**32 with no saturation and no flag.
- Simultaneous events:
  - A read and a write to the same address in one cycle return the new data.
  - Both read ports addressing the same register return identical data.
  - we with waddr==0 together with whilo counts as 1 event.
- Reset mid-operation:
  - Asserting rst while a write is presented aborts that write; no storage update occurs.
  - The first write after deassertion takes effect on the first rising edge with rst==1.
- No X propagation: every register has a defined reset value and is never left unassigned.

Test Plan:
- Reset: hold rst=0, drive we=1, waddr=5, wdata=32'hDEAD_BEEF, re1=1, raddr1=5 -> rdata1=0 and wr_count=0. Release rst and clock once with we=0 -> reg[5] still 0.
- Write then read: cycle0 we=1, waddr=3, wdata=32'h1234_5678; cycle1 we=0, re1=1, raddr1=3 -> rdata1=32'h1234_5678 and wr_count=1.
- Bypass: same cycle we=1, waddr=7, wdata=32'hA5A5_A5A5, re1=re2=1, raddr1=raddr2=7 -> rdata1=rdata2=32'hA5A5_A5A5 combinationally, before the edge.
- $0 protection: we=1, waddr=0, wdata=32'hFFFF_FFFF, then read raddr1=0 in the same cycle and the next -> 0 both times. wr_count unchanged.
- HI/LO: whilo=1, hi_i=32'h0000_0001, lo_i=32'h8000_0000 -> hi_o/lo_o show these values the same cycle and hold them after the edge with whilo=0. The same edge with we=1, waddr=9 -> wr_count+=2.
- Disabled read / async reset mid-run: re1=0, raddr1=3 -> rdata1=0. Pulse rst low between edges -> reg[3], HI and LO read 0 immediately, and wr_count=0.
